apb_master_arbiter: RTL and testbench

- Two-requester APB master that shares one APB bus (and the memory-mapped slave on it) between two internal requesters using round-robin arbitration.
- Converts a simple req/done handshake per requester into compliant APB SETUP/ACCESS sequences.
- Honours slave wait states via PREADY and aborts hung transfers with a timeout error.

---
 rtl/apb_master_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// PREADY wait states and timeout abort, one-cycle done/err/rdata pulses.
`timescale 1ns/1ps

module apb_master_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;

  logic               psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0]  paddr_d;
  logic [DATA_W-1:0]  pwdata_d;
  logic               done0_d, done1_d, err0_d, err1_d;
  logic [DATA_W-1:0]  rdata0_d, rdata1_d;
  logic               owner_d;

  logic [1:0]         mask_c, cand_c;
  logic               win_c;
  logic               start_c, finish_c, err_c;
  logic [DATA_W-1:0]  rd_c;

  // Eligible requests: hide the requester that is completing or just completed
  always_comb begin
    mask_c = 2'b00;
    if (state_q == S_IDLE) begin
      mask_c = {done1, done0};
    end else if (state_q == S_ACCESS) begin
      mask_c = owner ? 2'b10 : 2'b01;
    end
    cand_c = {req1, req0} & ~mask_c;
    win_c  = (cand_c == 2'b11) ? ~last_q : cand_c[1];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wcnt_d    = wcnt_q;
    owner_d   = owner;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = '0;
    pwdata_d  = '0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = '0;
    rdata1_d  = '0;
    start_c   = 1'b0;
    finish_c  = 1'b0;
    err_c     = 1'b0;
    rd_c      = '0;

    case (state_q)
      S_IDLE: begin
        start_c = |cand_c;
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        pwrite_d  = PWRITE;
        paddr_d   = PADDR;
        pwdata_d  = PWDATA;
      end
      S_ACCESS: begin
        if (PREADY) begin
          finish_c = 1'b1;
          err_c    = PSLVERR;
          rd_c     = PWRITE ? '0 : PRDATA;
        end else if (wcnt_q == CNT_LAST) begin
          finish_c = 1'b1;
          err_c    = 1'b1;
        end else begin
          wcnt_d    = wcnt_q + CNT_W'(1);
          psel_d    = 1'b1;
          penable_d = 1'b1;
          pwrite_d  = PWRITE;
          paddr_d   = PADDR;
          pwdata_d  = PWDATA;
        end
        if (finish_c) begin
          if (owner) begin
            done1_d  = 1'b1;
            err1_d   = err_c;
            rdata1_d = rd_c;
          end else begin
            done0_d  = 1'b1;
            err0_d   = err_c;
            rdata0_d = rd_c;
          end
          start_c = |cand_c;
          if (!start_c) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_c) begin
      state_d  = S_SETUP;
      psel_d   = 1'b1;
      owner_d  = win_c;
      last_d   = win_c;
      wcnt_d   = '0;
      pwrite_d = win_c ? wr1    : wr0;
      paddr_d  = win_c ? addr1  : addr0;
      pwdata_d = win_c ? wdata1 : wdata0;
    end
  end

  // State and registered outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      wcnt_q  <= '0;
      owner   <= 1'b0;
      busy    <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      owner   <= owner_d;
      busy    <= (state_d != S_IDLE);
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
      done0   <= done0_d;
      done1   <= done1_d;
      err0    <= err0_d;
      err1    <= err1_d;
      rdata0  <= rdata0_d;
      rdata1  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small behavioural APB slave.
`timescale 1ns/1ps

module tb_apb_master_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        busy, owner;

  int          vecs = 0;
  int          miscompares = 0;

  // Slave model state
  logic [31:0] mem [0:63];
  int          wcount = 0;
  int          waits;
  logic        hang;

  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .owner(owner)
  );

  always #5 PCLK = ~PCLK;

  // Slave: configurable wait states, hang mode, error at 0x1000_0000
  assign PREADY  = !hang && (wcount >= waits);
  assign PRDATA  = mem[PADDR[5:0]];
  assign PSLVERR = PSEL && PENABLE && (PADDR == 32'h1000_0000);

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcount <= wcount + 1;
    else                            wcount <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:0]] = PWDATA;
  end

  task automatic step();
    @(negedge PCLK);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] t_psel, t_pen, t_own, t_d0, t_d1;

    PRESETn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    hang = 1'b0; waits = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[19] = 32'h1313_1313;

    // Reset state
    step(); step();
    chk1("rst_psel", PSEL, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_done0", done0, 1'b0);
    chk1("rst_done1", done1, 1'b0);
    chk1("rst_err0", err0, 1'b0);
    chk32("rst_paddr", PADDR, 32'h0);
    PRESETn = 1'b1;
    step();

    // Single zero-wait write
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
    step();
    chk1("wr_setup_psel", PSEL, 1'b1);
    chk1("wr_setup_penable", PENABLE, 1'b0);
    chk32("wr_setup_paddr", PADDR, 32'h10);
    chk1("wr_setup_pwrite", PWRITE, 1'b1);
    chk32("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
    chk1("wr_setup_busy", busy, 1'b1);
    step();
    chk1("wr_access_psel", PSEL, 1'b1);
    chk1("wr_access_penable", PENABLE, 1'b1);
    chk1("wr_access_done0", done0, 1'b0);
    step();
    chk1("wr_done0", done0, 1'b1);
    chk1("wr_err0", err0, 1'b0);
    chk32("wr_rdata0", rdata0, 32'h0);
    chk1("wr_idle_psel", PSEL, 1'b0);
    chk1("wr_idle_busy", busy, 1'b0);
    req0 = 1'b0;
    step();
    chk1("wr_done0_pulse", done0, 1'b0);

    // Read back
    req0 = 1'b1; wr0 = 1'b0; wdata0 = '0;
    step(); step(); step();
    chk1("rd_done0", done0, 1'b1);
    chk32("rd_rdata0", rdata0, 32'hDEAD_BEEF);
    chk1("rd_err0", err0, 1'b0);
    req0 = 1'b0;
    step();

    // Three slave wait states
    waits = 3; req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h13;
    step();
    chk1("ws_setup_penable", PENABLE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("ws_psel", PSEL, 1'b1);
      chk1("ws_penable", PENABLE, 1'b1);
      chk32("ws_paddr", PADDR, 32'h13);
      chk1("ws_done0", done0, 1'b0);
    end
    step();
    chk1("ws_done", done0, 1'b1);
    chk32("ws_rdata0", rdata0, 32'h1313_1313);
    chk1("ws_psel_drop", PSEL, 1'b0);
    req0 = 1'b0; waits = 0;
    step();

    // Contention: both request, last grant was 0 so requester 1 goes first
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hA0;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h24; wdata1 = 32'hB1;
    // bit i = expected value in cycle i+1
    t_psel = 9'b011111111;
    t_pen  = 9'b010101010;
    t_own  = 9'b000110011;
    t_d0   = 9'b100010000;
    t_d1   = 9'b001000100;
    for (int c = 0; c < 9; c++) begin
      step();
      chk1("ct_psel", PSEL, t_psel[c]);
      chk1("ct_penable", PENABLE, t_pen[c]);
      chk1("ct_owner", owner, t_own[c]);
      chk1("ct_done0", done0, t_d0[c]);
      chk1("ct_done1", done1, t_d1[c]);
      chk1("ct_excl", done0 & done1, 1'b0);
      if (c == 6) req1 = 1'b0;
      if (c == 8) req0 = 1'b0;
    end
    step();
    chk1("ct_idle_busy", busy, 1'b0);

    // Slave error on requester 1, then a clean access
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h1000_0000;
    step();
    chk1("er_owner", owner, 1'b1);
    step(); step();
    chk1("er_done1", done1, 1'b1);
    chk1("er_err1", err1, 1'b1);
    chk1("er_done0", done0, 1'b0);
    chk32("er_rdata1", rdata1, 32'h0);
    req1 = 1'b0;
    step();
    req1 = 1'b1; addr1 = 32'h24;
    step(); step(); step();
    chk1("ok_done1", done1, 1'b1);
    chk1("ok_err1", err1, 1'b0);
    chk32("ok_rdata1", rdata1, 32'hB1);
    req1 = 1'b0;
    step();

    // Timeout after 16 ACCESS cycles
    hang = 1'b1; req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      chk1("to_penable", PENABLE, 1'b1);
      chk1("to_done0", done0, 1'b0);
    end
    step();
    chk1("to_done", done0, 1'b1);
    chk1("to_err0", err0, 1'b1);
    chk32("to_rdata0", rdata0, 32'h0);
    chk1("to_psel", PSEL, 1'b0);
    chk1("to_busy", busy, 1'b0);
    req0 = 1'b0; hang = 1'b0;
    step();
    chk1("to_idle_psel", PSEL, 1'b0);

    // Reset during the second wait cycle, then tie after release
    hang = 1'b1; req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
    step(); step(); step();
    chk1("rm_penable", PENABLE, 1'b1);
    PRESETn = 1'b0;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h10;
    #1;
    chk1("rm_psel", PSEL, 1'b0);
    chk1("rm_penable0", PENABLE, 1'b0);
    chk1("rm_busy", busy, 1'b0);
    chk1("rm_done0", done0, 1'b0);
    chk1("rm_err0", err0, 1'b0);
    step();
    PRESETn = 1'b1; hang = 1'b0;
    step();
    chk1("rm_grant_psel", PSEL, 1'b1);
    chk1("rm_grant_owner", owner, 1'b0);
    step();
    step();
    chk1("rm_done0_after", done0, 1'b1);
    chk32("rm_rdata0", rdata0, 32'hDEAD_BEEF);
    chk1("rm_b2b_owner", owner, 1'b1);
    chk1("rm_b2b_psel", PSEL, 1'b1);
    chk1("rm_b2b_penable", PENABLE, 1'b0);
    req0 = 1'b0;
    step(); step();
    chk1("rm_done1", done1, 1'b1);
    chk32("rm_rdata1", rdata1, 32'hDEAD_BEEF);
    req1 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
